// File: rtl/ash_sequencer_pkg.sv
// Shared definitions for the ASH/ASHC sequencer: FSM encodings, condition-code
// bit positions and the shift-count magnitude helper.
package ash_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ash_state_e;

  localparam int CC_N = 3;
  localparam int CC_Z = 2;
  localparam int CC_V = 1;
  localparam int CC_C = 0;

  // Magnitude of a 6-bit two's-complement count; -32 maps to 6'd32.
  function automatic logic [5:0] abs_count(input logic [5:0] cnt);
    return cnt[5] ? (~cnt + 6'd1) : cnt;
  endfunction

endpackage

// File: rtl/ash_step.sv
// 32-bit one-bit-per-cycle arithmetic shifter with carry/overflow capture.
// Exposes the value each register takes on the coming edge.
module ash_step (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic        dir,
  input  logic        ashc,
  input  logic [31:0] load_val,
  output logic [31:0] acc_d,
  output logic        c_d,
  output logic        v_d
);

  logic [31:0] acc_r;
  logic        c_r;
  logic        v_r;

  // Next shifter state: load clears C/V; left steps accumulate sign changes.
  always_comb begin
    acc_d = acc_r;
    c_d   = c_r;
    v_d   = v_r;
    if (load) begin
      acc_d = load_val;
      c_d   = 1'b0;
      v_d   = 1'b0;
    end else if (step) begin
      if (dir) begin
        acc_d = {acc_r[31], acc_r[31:1]};
        // ASH keeps its operand in the high half, so bit 16 is its LSB.
        c_d   = ashc ? acc_r[0] : acc_r[16];
      end else begin
        acc_d = {acc_r[30:0], 1'b0};
        c_d   = acc_r[31];
        v_d   = v_r | (acc_r[31] ^ acc_r[30]);
      end
    end else begin
      acc_d = acc_r;
    end
  end

  // Shifter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r <= 32'd0;
      c_r   <= 1'b0;
      v_r   <= 1'b0;
    end else begin
      acc_r <= acc_d;
      c_r   <= c_d;
      v_r   <= v_d;
    end
  end

endmodule

// File: rtl/ash_sequencer.sv
// PDP-11 ASH/ASHC multi-cycle controller: latches a request, steps the shifter
// |count| times, then presents result and N/Z/V/C with a one-cycle done pulse.
module ash_sequencer
  import ash_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_ashc,
  input  logic [5:0]  count,
  input  logic [15:0] src_hi,
  input  logic [15:0] src_lo,
  output logic        busy,
  output logic        done,
  output logic [15:0] res_hi,
  output logic [15:0] res_lo,
  output logic [3:0]  cc
);

  ash_state_e  state_r, state_nxt;
  logic [5:0]  steps_r;
  logic [5:0]  abs_s;
  logic        dir_r, ashc_r;
  logic [15:0] src_lo_r;
  logic        load_s, step_s, finish_s, ashc_s;
  logic [15:0] lo_s;
  logic [31:0] acc_d;
  logic        c_d, v_d;
  logic [3:0]  cc_s;

  assign abs_s = abs_count(count);

  ash_step u_step (
    .clk      (clk),
    .reset    (reset),
    .load     (load_s),
    .step     (step_s),
    .dir      (dir_r),
    .ashc     (ashc_r),
    .load_val (is_ashc ? {src_hi, src_lo} : {src_hi, 16'h0000}),
    .acc_d    (acc_d),
    .c_d      (c_d),
    .v_d      (v_d)
  );

  // Next-state and shifter control.
  always_comb begin
    state_nxt = state_r;
    load_s    = 1'b0;
    step_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          load_s    = 1'b1;
          state_nxt = (abs_s == 6'd0) ? ST_DONE : ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        step_s    = 1'b1;
        state_nxt = (steps_r == 6'd1) ? ST_DONE : ST_RUN;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Zero-count requests finish straight from IDLE, so take mode/low word live then.
  always_comb begin
    finish_s = (state_nxt == ST_DONE);
    ashc_s   = load_s ? is_ashc : ashc_r;
    lo_s     = load_s ? src_lo : src_lo_r;
    cc_s       = 4'b0000;
    cc_s[CC_N] = acc_d[31];
    cc_s[CC_Z] = ashc_s ? (acc_d == 32'd0) : (acc_d[31:16] == 16'd0);
    cc_s[CC_V] = v_d;
    cc_s[CC_C] = c_d;
  end

  // FSM state, step counter and latched operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      steps_r  <= 6'd0;
      dir_r    <= 1'b0;
      ashc_r   <= 1'b0;
      src_lo_r <= 16'd0;
    end else begin
      state_r <= state_nxt;
      if (load_s) begin
        steps_r  <= abs_s;
        dir_r    <= count[5];
        ashc_r   <= is_ashc;
        src_lo_r <= src_lo;
      end else if (step_s) begin
        steps_r <= steps_r - 6'd1;
      end
    end
  end

  // Registered outputs; results update only on entry to DONE and hold otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      res_hi <= 16'd0;
      res_lo <= 16'd0;
      cc     <= 4'b0000;
    end else begin
      busy <= (state_nxt != ST_IDLE);
      done <= finish_s;
      if (finish_s) begin
        res_hi <= acc_d[31:16];
        res_lo <= ashc_s ? acc_d[15:0] : lo_s;
        cc     <= cc_s;
      end
    end
  end

endmodule
